stepper_seq: RTL and testbench
==============================

STEPPER_SEQ -- requirements
Module: stepper_seq

Interface
REQ-001 SHALL have parameter PRD_W, default 16, meaning step-period counter width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning step-count width.
REQ-003 SHALL have port mclk  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cfg_en  input  1  sequencer enable; low forces abort and blocks commands.
REQ-006 SHALL have port cfg_half  input  1  1 = half-step (8 phases), 0 = full-step (4 phases).
REQ-007 SHALL have port cfg_dir  input  1  1 = forward (phase index increments), 0 = reverse.
REQ-008 SHALL have port cfg_period  input  PRD_W  mclk cycles per step minus 1.
REQ-009 SHALL have port cfg_hold  input  1  1 = keep coils energized while idle.
REQ-010 SHALL have port cmd_valid  input  1  move request.
REQ-011 SHALL have port cmd_steps  input  CNT_W  number of steps to move.
REQ-012 SHALL have port cmd_ready  output  1  request accepted when high with cmd_valid.
REQ-013 SHALL have port cmd_abort  input  1  stop current move.
REQ-014 SHALL have ports sm_a1, sm_a2, sm_b1, sm_b2  output  1 each  coil drives to the pad mux.
REQ-015 SHALL have port busy  output  1  high in RUN.
REQ-016 SHALL have port done  output  1  one-cycle pulse at move end.
REQ-017 SHALL have port aborted  output  1  one-cycle pulse, coincident with done, when move ended by abort.
REQ-018 SHALL have port steps_left  output  CNT_W  remaining steps.
REQ-019 SHALL have port phase  output  3  current phase index.

Function
REQ-020 SHALL implement states IDLE and RUN; cmd_ready = (state==IDLE) & cfg_en.
REQ-021 On accept, SHALL latch cfg_dir, cfg_half, cfg_period and load steps_left = cmd_steps and prescaler = cfg_period; later cfg changes SHALL not affect that move.
REQ-022 Accept with cmd_steps==0 SHALL stay IDLE and pulse done the next cycle, phase unchanged.
REQ-023 Accept with cmd_steps>0 SHALL enter RUN next cycle; prescaler decrements each RUN cycle; at 0 SHALL advance phase, decrement steps_left, reload latched period.
REQ-024 First step SHALL occur period+1 cycles after the accept edge; subsequent steps every period+1 cycles; period 0 = one step per cycle.
REQ-025 Phase table (a1 a2 b1 b2): 0=1000, 1=1010, 2=0010, 3=0110, 4=0100, 5=0101, 6=0001, 7=1001.
REQ-026 Half-step SHALL move phase +/-1 mod 8; full-step SHALL move +/-2 mod 8 from odd phase, +/-1 from even phase (aligns to odd, two-coil).
REQ-027 The step that makes steps_left 0 SHALL return to IDLE and pulse done on the following cycle.
REQ-028 cmd_abort or cfg_en low in RUN SHALL return to IDLE next cycle with no further phase change, steps_left frozen, done and aborted pulsed.
REQ-029 Abort coincident with the final step SHALL complete normally (aborted low); abort in IDLE SHALL be ignored.
REQ-030 Coil outputs SHALL equal table[phase] when busy or cfg_hold, else 0000; registered, changing on the same edge as phase.
REQ-031 Phase SHALL be retained between moves.

Reset
REQ-032 reset SHALL force IDLE, phase 0, steps_left 0, prescaler 0, coils 0000, done/aborted/busy 0, immediately and independent of mclk.
REQ-033 reset mid-move SHALL discard the move without done pulse; cmd_ready SHALL be high the first edge after release if cfg_en.

Verification
REQ-034 half, fwd, period 3, steps 4 from phase 0 -> phase 1,2,3,4 at cycles 4,8,12,16 after accept; done at 17; coils end 0100.
REQ-035 full, rev, period 0, steps 3 from phase 0 -> phase 7,5,3 on consecutive cycles; coils 1001,0101,0110.
REQ-036 steps 10, abort after 3rd step -> steps_left 7, done+aborted one pulse, phase frozen, busy low.
REQ-037 cmd_steps 0 -> no phase change, done pulses one cycle after accept, aborted low.
REQ-038 cfg_hold 0 idle -> coils 0000; cfg_hold 1 -> table[phase]; reset asserted mid-RUN -> coils 0000 without clock, no done.

Source files
------------

// File: rtl/stepper_seq.sv
// Unipolar/bipolar stepper sequencer: paced phase stepping through an 8-entry coil table.
// Latched per-move config; registered coil drives; done/aborted pulse one cycle after move end.
module stepper_seq #(
  parameter int PRD_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             cfg_en,
  input  logic             cfg_half,
  input  logic             cfg_dir,
  input  logic [PRD_W-1:0] cfg_period,
  input  logic             cfg_hold,
  input  logic             cmd_valid,
  input  logic [CNT_W-1:0] cmd_steps,
  output logic             cmd_ready,
  input  logic             cmd_abort,
  output logic             sm_a1,
  output logic             sm_a2,
  output logic             sm_b1,
  output logic             sm_b2,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_left,
  output logic [2:0]       phase
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [PRD_W-1:0] presc_q, presc_d;
  logic [PRD_W-1:0] period_q, period_d;
  logic             dir_q, dir_d;
  logic             half_q, half_d;
  logic [3:0]       coils_q, coils_d;
  logic             fin_q, fin_d;
  logic             abt_q, abt_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             last_step;

  function automatic logic [3:0] coil_tbl(input logic [2:0] p);
    logic [3:0] c;
    case (p)
      3'd0:    c = 4'b1000;
      3'd1:    c = 4'b1010;
      3'd2:    c = 4'b0010;
      3'd3:    c = 4'b0110;
      3'd4:    c = 4'b0100;
      3'd5:    c = 4'b0101;
      3'd6:    c = 4'b0001;
      default: c = 4'b1001;
    endcase
    return c;
  endfunction

  // Full-step from an even phase moves by one so the rotor lands on a two-coil position.
  function automatic logic [2:0] next_phase(input logic [2:0] p, input logic half, input logic dir);
    logic [2:0] inc;
    inc = (half || !p[0]) ? 3'd1 : 3'd2;
    return dir ? p + inc : p - inc;
  endfunction

  assign last_step = (presc_q == '0) && (steps_q == CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    steps_d   = steps_q;
    presc_d   = presc_q;
    period_d  = period_q;
    dir_d     = dir_q;
    half_d    = half_q;
    fin_d     = 1'b0;
    abt_d     = 1'b0;
    done_d    = fin_q;
    aborted_d = abt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cfg_en) begin
          dir_d    = cfg_dir;
          half_d   = cfg_half;
          period_d = cfg_period;
          steps_d  = cmd_steps;
          presc_d  = cfg_period;
          if (cmd_steps == '0) fin_d = 1'b1;
          else                 state_d = RUN;
        end
      end
      RUN: begin
        // The final step wins over a coincident abort.
        if (last_step) begin
          phase_d = next_phase(phase_q, half_q, dir_q);
          steps_d = steps_q - CNT_W'(1);
          presc_d = period_q;
          state_d = IDLE;
          fin_d   = 1'b1;
        end else if (cmd_abort || !cfg_en) begin
          state_d = IDLE;
          fin_d   = 1'b1;
          abt_d   = 1'b1;
        end else if (presc_q == '0) begin
          phase_d = next_phase(phase_q, half_q, dir_q);
          steps_d = steps_q - CNT_W'(1);
          presc_d = period_q;
        end else begin
          presc_d = presc_q - PRD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    coils_d = (state_d == RUN || cfg_hold) ? coil_tbl(phase_d) : 4'b0000;
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      steps_q   <= '0;
      presc_q   <= '0;
      period_q  <= '0;
      dir_q     <= 1'b0;
      half_q    <= 1'b0;
      coils_q   <= 4'b0000;
      fin_q     <= 1'b0;
      abt_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      steps_q   <= steps_d;
      presc_q   <= presc_d;
      period_q  <= period_d;
      dir_q     <= dir_d;
      half_q    <= half_d;
      coils_q   <= coils_d;
      fin_q     <= fin_d;
      abt_q     <= abt_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE) && cfg_en;
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign steps_left = steps_q;
  assign phase      = phase_q;
  assign {sm_a1, sm_a2, sm_b1, sm_b2} = coils_q;

endmodule

// File: tb/tb_stepper_seq.sv
// Directed bench for stepper_seq with hand-computed phase/coil/timing expectations.
module tb_stepper_seq;

  logic        mclk, reset, cfg_en, cfg_half, cfg_dir, cfg_hold;
  logic [15:0] cfg_period, cmd_steps, steps_left;
  logic        cmd_valid, cmd_ready, cmd_abort;
  logic        sm_a1, sm_a2, sm_b1, sm_b2, busy, done, aborted;
  logic [2:0]  phase;
  logic [3:0]  coils;

  int n_chk = 0;
  int n_err = 0;

  stepper_seq #(.PRD_W(16), .CNT_W(16)) dut (
    .mclk(mclk), .reset(reset), .cfg_en(cfg_en), .cfg_half(cfg_half),
    .cfg_dir(cfg_dir), .cfg_period(cfg_period), .cfg_hold(cfg_hold),
    .cmd_valid(cmd_valid), .cmd_steps(cmd_steps), .cmd_ready(cmd_ready),
    .cmd_abort(cmd_abort), .sm_a1(sm_a1), .sm_a2(sm_a2), .sm_b1(sm_b1),
    .sm_b2(sm_b2), .busy(busy), .done(done), .aborted(aborted),
    .steps_left(steps_left), .phase(phase)
  );

  assign coils = {sm_a1, sm_a2, sm_b1, sm_b2};

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] exp_ph [3];
    logic [3:0] exp_co [3];
    int dn, mis;
    exp_ph = '{3'd7, 3'd5, 3'd3};
    exp_co = '{4'b1001, 4'b0101, 4'b0110};

    reset = 1'b1; cfg_en = 1'b1; cfg_half = 1'b0; cfg_dir = 1'b1;
    cfg_period = 16'd0; cfg_hold = 1'b0; cmd_valid = 1'b0;
    cmd_steps = 16'd0; cmd_abort = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_phase", phase, 0);
    check("rst_steps", steps_left, 0);
    check("rst_coils", coils, 0);

    cfg_hold = 1'b1;
    @(negedge mclk); reset = 1'b0;
    tick();
    check("ready_after_rst", cmd_ready, 1);
    check("hold_idle_coils", coils, 4'b1000);
    cfg_en = 1'b0; #1;
    check("ready_en_low", cmd_ready, 0);
    cfg_en = 1'b1; #1;

    // half, fwd, period 3, 4 steps; cfg changed after accept must not matter
    cfg_half = 1'b1; cfg_dir = 1'b1; cfg_period = 16'd3; cmd_steps = 16'd4; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; cfg_period = 16'd0; cfg_dir = 1'b0; cfg_half = 1'b0;
    check("t1_busy", busy, 1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("t1_phase", phase, k / 4);
      check("t1_steps", steps_left, 4 - k / 4);
    end
    check("t1_busy_end", busy, 0);
    check("t1_done_early", done, 0);
    tick();
    check("t1_done", done, 1);
    check("t1_aborted", aborted, 0);
    tick();
    check("t1_done_clr", done, 0);
    check("t1_coils", coils, 4'b0100);

    // full, rev, period 0, 3 steps from phase 0
    reset = 1'b1; #1;
    check("rst2_phase", phase, 0);
    @(negedge mclk); reset = 1'b0;
    tick();
    cfg_half = 1'b0; cfg_dir = 1'b0; cfg_period = 16'd0; cmd_steps = 16'd3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_phase", phase, exp_ph[i]);
      check("t2_coils", coils, exp_co[i]);
      check("t2_steps", steps_left, 2 - i);
    end
    tick();
    check("t2_done", done, 1);
    tick();

    // 10 steps, abort after the 3rd step (phase 3 -> 4,5,6)
    cfg_half = 1'b1; cfg_dir = 1'b1; cfg_period = 16'd1; cmd_steps = 16'd10; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (6) tick();
    check("t3_phase_pre", phase, 6);
    check("t3_steps_pre", steps_left, 7);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    check("t3_busy", busy, 0);
    dn = 0; mis = 0;
    dn += int'(done); mis += int'(done !== aborted);
    repeat (3) begin
      tick();
      dn += int'(done); mis += int'(done !== aborted);
    end
    check("t3_done_pulses", dn, 1);
    check("t3_abort_coinc", mis, 0);
    check("t3_phase_frozen", phase, 6);
    check("t3_steps_frozen", steps_left, 7);

    cmd_abort = 1'b1;
    tick(); tick();
    cmd_abort = 1'b0;
    check("idle_abort_done", done, 0);
    check("idle_abort_phase", phase, 6);

    // zero-step move
    cmd_steps = 16'd0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_done_early", done, 0);
    tick();
    check("t4_done", done, 1);
    check("t4_aborted", aborted, 0);
    check("t4_phase", phase, 6);
    tick();
    check("t4_done_clr", done, 0);

    // abort coincident with the final step completes normally
    cfg_half = 1'b1; cfg_dir = 1'b1; cfg_period = 16'd0; cmd_steps = 16'd1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    check("t5_phase", phase, 7);
    check("t5_busy", busy, 0);
    tick();
    check("t5_done", done, 1);
    check("t5_aborted", aborted, 0);
    check("t5_steps", steps_left, 0);

    // hold behaviour and reset mid-move
    cfg_hold = 1'b0;
    tick();
    check("nohold_coils", coils, 4'b0000);
    cfg_hold = 1'b1;
    tick();
    check("hold_coils", coils, 4'b1001);
    cfg_period = 16'd2; cmd_steps = 16'd5; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    check("t6_phase1", phase, 0);
    check("t6_coils1", coils, 4'b1000);
    repeat (3) tick();
    check("t6_phase2", phase, 1);
    check("t6_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_coils", coils, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_phase", phase, 0);
    check("t6_rst_steps", steps_left, 0);
    @(negedge mclk); reset = 1'b0;
    dn = 0;
    tick();
    check("t6_ready", cmd_ready, 1);
    dn += int'(done);
    repeat (3) begin
      tick();
      dn += int'(done);
    end
    check("t6_no_done", dn, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
